// File: rtl/gather_pkg.sv
// Shared types and helpers for the gather-network output-VC allocator.
// Optional candidate checking in the allocator is enabled by defining GATHER_VA_CHECK_EN.
`ifndef CN
`define CN 4
`endif

package gather_pkg;

    typedef enum logic {VC_FREE, VC_BUSY} vc_state_e;
    typedef enum logic {IN_IDLE, IN_OWN}  in_state_e;

    localparam int NUM_IN_DEF = 5;
    localparam int IDX_W      = $clog2(NUM_IN_DEF);
    localparam int CN_DEF     = `CN;

    // Isolates the lowest set bit; a multi-hot candidate resolves to its lowest VC.
    function automatic logic [31:0] onehot_lowest(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/gather_rr_arb.sv
// N-way round-robin arbiter: first requester at or after ptr (wrapping) wins.
module gather_rr_arb #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win,
    output logic          any
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        win = '0;
        any = 1'b0;
        for (int off = 0; off < N; off++) begin
            k = (int'(ptr) + off) % N;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                win    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/gather_vc_allocator.sv
// Output-VC allocator: per-VC round-robin grant of free VCs, held until the owner's tail releases.
// Define GATHER_VA_CHECK_EN to add the sticky cand_err port and candidate checking.
module gather_vc_allocator
    import gather_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int CN     = CN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN-1:0]    req_valid,
    input  logic [NUM_IN*CN-1:0] req_vc,
    input  logic [NUM_IN-1:0]    vc_release,
    output logic [NUM_IN-1:0]    grant,
    output logic [NUM_IN*CN-1:0] grant_vc,
    output logic [CN-1:0]        vc_busy
`ifdef GATHER_VA_CHECK_EN
   ,output logic [NUM_IN-1:0]    cand_err
`endif
);

    localparam int IW = $clog2(NUM_IN);

    in_state_e         in_state [NUM_IN];
    vc_state_e         vc_state [CN];
    logic [IW-1:0]     vc_owner [CN];
    logic [IW-1:0]     rr_ptr   [CN];

    logic [CN-1:0]     target   [NUM_IN];
    logic [NUM_IN-1:0] req_mat  [CN];
    logic [NUM_IN-1:0] arb_gnt  [CN];
    logic [IW-1:0]     arb_win  [CN];
    logic [CN-1:0]     arb_any;
    logic [NUM_IN-1:0] won;

    // Request matrix is built from registered state only; a VC freed this cycle is not offered.
    always_comb begin
        for (int v = 0; v < CN; v++) req_mat[v] = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            target[i] = CN'(onehot_lowest(32'(req_vc[i*CN +: CN])));
            for (int v = 0; v < CN; v++)
                req_mat[v][i] = req_valid[i] && (in_state[i] == IN_IDLE) &&
                                target[i][v] && (vc_state[v] == VC_FREE);
        end
    end

    for (genvar v = 0; v < CN; v++) begin : g_arb
        gather_rr_arb #(.N(NUM_IN), .IW(IW)) u_arb (
            .req (req_mat[v]),
            .ptr (rr_ptr[v]),
            .gnt (arb_gnt[v]),
            .win (arb_win[v]),
            .any (arb_any[v])
        );
    end

    always_comb begin
        won = '0;
        for (int v = 0; v < CN; v++) won = won | arb_gnt[v];
        for (int v = 0; v < CN; v++) vc_busy[v] = (vc_state[v] == VC_BUSY);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the state arrays are tiny and all of them are cleared on reset, unlike bulk memories.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            grant_vc <= '0;
            for (int v = 0; v < CN; v++) begin
                vc_state[v] <= VC_FREE;
                vc_owner[v] <= '0;
                rr_ptr[v]   <= '0;
            end
            for (int i = 0; i < NUM_IN; i++) in_state[i] <= IN_IDLE;
        end else begin
            grant <= won;
            for (int v = 0; v < CN; v++) begin
                if (vc_state[v] == VC_BUSY && vc_release[vc_owner[v]]) begin
                    vc_state[v] <= VC_FREE;
                end else if (arb_any[v]) begin
                    vc_state[v] <= VC_BUSY;
                    vc_owner[v] <= arb_win[v];
                    rr_ptr[v]   <= (arb_win[v] == IW'(NUM_IN - 1)) ? '0 : arb_win[v] + 1'b1;
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_state[i] == IN_OWN && vc_release[i]) begin
                    in_state[i]           <= IN_IDLE;
                    grant_vc[i*CN +: CN] <= '0;
                end else if (in_state[i] == IN_IDLE && won[i]) begin
                    in_state[i]           <= IN_OWN;
                    grant_vc[i*CN +: CN] <= target[i];
                end
            end
        end
    end

`ifdef GATHER_VA_CHECK_EN
    logic [NUM_IN-1:0] bad;

    always_comb begin
        logic [CN-1:0] s;
        s   = '0;
        bad = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            s      = req_vc[i*CN +: CN];
            bad[i] = req_valid[i] && ((s == '0) || ((s & (s - 1'b1)) != '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cand_err <= '0;
        else     cand_err <= cand_err | bad;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_IN; i++)
                if (bad[i]) $error("gather_vc_allocator: input %0d candidate VC not one-hot", i);
        end
    end
`endif

endmodule

// File: tb/tb_gather_vc_allocator.sv
// Directed self-checking bench for gather_vc_allocator (NUM_IN=5, CN=4).
module tb_gather_vc_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid;
    logic [19:0] req_vc;
    logic [4:0]  vc_release;
    logic [4:0]  grant;
    logic [19:0] grant_vc;
    logic [3:0]  vc_busy;
`ifdef GATHER_VA_CHECK_EN
    logic [4:0]  cand_err;
`endif

    int checks   = 0;
    int failures = 0;

    gather_vc_allocator #(.NUM_IN(5), .CN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_vc     (req_vc),
        .vc_release (vc_release),
        .grant      (grant),
        .grant_vc   (grant_vc),
        .vc_busy    (vc_busy)
`ifdef GATHER_VA_CHECK_EN
       ,.cand_err   (cand_err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_vc     = '0;
        vc_release = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (grant !== 5'b0)     begin failures++; $display("FAIL reset_grant: got %b want %b", grant, 5'b0); end
        checks++; if (grant_vc !== 20'h0) begin failures++; $display("FAIL reset_grant_vc: got %h want %h", grant_vc, 20'h0); end
        checks++; if (vc_busy !== 4'b0)   begin failures++; $display("FAIL reset_vc_busy: got %b want %b", vc_busy, 4'b0); end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid[0] = 1'b1; req_vc[3:0] = 4'b0100;
        step();
        checks++; if (grant !== 5'b00001)     begin failures++; $display("FAIL single_grant: got %b want %b", grant, 5'b00001); end
        checks++; if (grant_vc[3:0] !== 4'b0100) begin failures++; $display("FAIL single_grant_vc: got %b want %b", grant_vc[3:0], 4'b0100); end
        checks++; if (vc_busy !== 4'b0100)    begin failures++; $display("FAIL single_vc_busy: got %b want %b", vc_busy, 4'b0100); end
        req_valid[0] = 1'b0;
        step();
        checks++; if (grant !== 5'b0)         begin failures++; $display("FAIL single_pulse: got %b want %b", grant, 5'b0); end
        checks++; if (grant_vc !== 20'h00004) begin failures++; $display("FAIL single_hold: got %h want %h", grant_vc, 20'h00004); end
        vc_release[0] = 1'b1;
        step();
        vc_release[0] = 1'b0;
        checks++; if (vc_busy !== 4'b0)       begin failures++; $display("FAIL single_rel_busy: got %b want %b", vc_busy, 4'b0); end
        checks++; if (grant_vc !== 20'h0)     begin failures++; $display("FAIL single_rel_vc: got %h want %h", grant_vc, 20'h0); end
    endtask

    task automatic test_contention();
        apply_reset();
        req_valid = 5'b11010;
        req_vc[7:4] = 4'b0001; req_vc[15:12] = 4'b0001; req_vc[19:16] = 4'b0001;
        step();
        checks++; if (grant !== 5'b00010) begin failures++; $display("FAIL cont_first: got %b want %b", grant, 5'b00010); end
        req_valid[1] = 1'b0; vc_release[1] = 1'b1;
        step();
        vc_release[1] = 1'b0;
        checks++; if (grant !== 5'b0)     begin failures++; $display("FAIL cont_no_reuse: got %b want %b", grant, 5'b0); end
        checks++; if (vc_busy !== 4'b0)   begin failures++; $display("FAIL cont_freed: got %b want %b", vc_busy, 4'b0); end
        step();
        checks++; if (grant !== 5'b01000) begin failures++; $display("FAIL cont_second: got %b want %b", grant, 5'b01000); end
        req_valid[3] = 1'b0; vc_release[3] = 1'b1;
        step();
        vc_release[3] = 1'b0;
        step();
        checks++; if (grant !== 5'b10000) begin failures++; $display("FAIL cont_third: got %b want %b", grant, 5'b10000); end
        req_valid[4] = 1'b0; vc_release[4] = 1'b1;
        step();
        vc_release[4] = 1'b0;
        // Pointer wrapped to 0: in0 beats in1.
        req_valid = 5'b00011; req_vc[3:0] = 4'b0001; req_vc[7:4] = 4'b0001;
        step();
        checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL cont_ptr_wrap: got %b want %b", grant, 5'b00001); end
        checks++; if (grant_vc !== 20'h00001) begin failures++; $display("FAIL cont_ptr_vc: got %h want %h", grant_vc, 20'h00001); end
    endtask

    task automatic test_parallel();
        apply_reset();
        req_valid = 5'b00111;
        req_vc[3:0] = 4'b0001; req_vc[7:4] = 4'b0010; req_vc[11:8] = 4'b1000;
        step();
        req_valid = '0;
        checks++; if (grant !== 5'b00111)     begin failures++; $display("FAIL par_grant: got %b want %b", grant, 5'b00111); end
        checks++; if (vc_busy !== 4'b1011)    begin failures++; $display("FAIL par_busy: got %b want %b", vc_busy, 4'b1011); end
        checks++; if (grant_vc !== 20'h00821) begin failures++; $display("FAIL par_grant_vc: got %h want %h", grant_vc, 20'h00821); end
    endtask

    task automatic test_release_reuse();
        apply_reset();
        req_valid[0] = 1'b1; req_vc[3:0] = 4'b0010;
        step();
        checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL reuse_own: got %b want %b", grant, 5'b00001); end
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b1; req_vc[11:8] = 4'b0010;
        step();
        checks++; if (grant !== 5'b0)     begin failures++; $display("FAIL reuse_blocked: got %b want %b", grant, 5'b0); end
        vc_release[0] = 1'b1;
        step();
        vc_release[0] = 1'b0;
        checks++; if (grant !== 5'b0)     begin failures++; $display("FAIL reuse_same_cycle: got %b want %b", grant, 5'b0); end
        checks++; if (vc_busy !== 4'b0)   begin failures++; $display("FAIL reuse_free: got %b want %b", vc_busy, 4'b0); end
        step();
        req_valid[2] = 1'b0;
        checks++; if (grant !== 5'b00100) begin failures++; $display("FAIL reuse_grant: got %b want %b", grant, 5'b00100); end
        checks++; if (grant_vc !== 20'h00200) begin failures++; $display("FAIL reuse_vc: got %h want %h", grant_vc, 20'h00200); end
    endtask

    task automatic test_illegal();
        apply_reset();
        req_valid[4] = 1'b1; req_vc[19:16] = 4'b0000;
        step();
        step();
        checks++; if (grant !== 5'b0)   begin failures++; $display("FAIL ill_zero_grant: got %b want %b", grant, 5'b0); end
        checks++; if (vc_busy !== 4'b0) begin failures++; $display("FAIL ill_zero_busy: got %b want %b", vc_busy, 4'b0); end
`ifdef GATHER_VA_CHECK_EN
        checks++; if (cand_err[4] !== 1'b1) begin failures++; $display("FAIL ill_cand_err: got %b want %b", cand_err[4], 1'b1); end
`endif
        req_valid[4] = 1'b0;
        req_valid[1] = 1'b1; req_vc[7:4] = 4'b0110;
        step();
        req_valid[1] = 1'b0;
        checks++; if (grant !== 5'b00010)   begin failures++; $display("FAIL ill_multi_grant: got %b want %b", grant, 5'b00010); end
        checks++; if (grant_vc !== 20'h00020) begin failures++; $display("FAIL ill_multi_vc: got %h want %h", grant_vc, 20'h00020); end
        vc_release[3] = 1'b1;
        step();
        vc_release[3] = 1'b0;
        checks++; if (vc_busy !== 4'b0010)  begin failures++; $display("FAIL ill_idle_release: got %b want %b", vc_busy, 4'b0010); end
        checks++; if (grant_vc !== 20'h00020) begin failures++; $display("FAIL ill_idle_rel_vc: got %h want %h", grant_vc, 20'h00020); end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        req_valid = 5'b00011; req_vc[3:0] = 4'b0001; req_vc[7:4] = 4'b0010;
        step();
        checks++; if (vc_busy !== 4'b0011) begin failures++; $display("FAIL midop_busy: got %b want %b", vc_busy, 4'b0011); end
        req_valid = 5'b00100; req_vc[11:8] = 4'b0001;
        step();
        checks++; if (grant !== 5'b0)      begin failures++; $display("FAIL midop_wait: got %b want %b", grant, 5'b0); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (vc_busy !== 4'b0)    begin failures++; $display("FAIL midop_rst_busy: got %b want %b", vc_busy, 4'b0); end
        checks++; if (grant_vc !== 20'h0)  begin failures++; $display("FAIL midop_rst_vc: got %h want %h", grant_vc, 20'h0); end
        checks++; if (grant !== 5'b0)      begin failures++; $display("FAIL midop_rst_grant: got %b want %b", grant, 5'b0); end
        step();
        req_valid = '0;
        checks++; if (grant !== 5'b00100)  begin failures++; $display("FAIL midop_rearb: got %b want %b", grant, 5'b00100); end
        checks++; if (vc_busy !== 4'b0001) begin failures++; $display("FAIL midop_rearb_busy: got %b want %b", vc_busy, 4'b0001); end
        checks++; if (grant_vc !== 20'h00100) begin failures++; $display("FAIL midop_rearb_vc: got %h want %h", grant_vc, 20'h00100); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_release_reuse();
        test_illegal();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
